// File: rtl/echo_capture.sv
// Ultrasonic trigger generator and echo pulse-width capture feeding the height stage.
// Define ECHO_MEDIAN3_EN to publish a 3-sample running median (one extra cycle of latency).
module echo_capture #(
  parameter int unsigned TRIG_TICKS   = 120,
  parameter int unsigned PERIOD_TICKS = 720000,
  parameter int unsigned RISE_TIMEOUT = 24000,
  parameter int unsigned ECHO_TIMEOUT = 456000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        echo_in,
  output logic        trig,
  output logic [31:0] echo_width,
  output logic        width_valid,
  output logic        timeout,
  output logic        no_echo
);

  if (TRIG_TICKS + RISE_TIMEOUT + ECHO_TIMEOUT >= PERIOD_TICKS) begin : g_bad_timing
    $error("echo_capture: TRIG_TICKS + RISE_TIMEOUT + ECHO_TIMEOUT must be below PERIOD_TICKS");
  end

  localparam logic [31:0] TRIG_LAST   = 32'(TRIG_TICKS - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_TICKS - 1);
  localparam logic [31:0] RISE_LAST   = 32'(RISE_TIMEOUT - 1);
  localparam logic [31:0] ECHO_MAX    = 32'(ECHO_TIMEOUT);

  typedef enum logic [1:0] {
    S_TRIG      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_MEASURE   = 2'd2,
    S_HOLDOFF   = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic        trig_q, trig_d;
  logic        no_echo_q, no_echo_d;
  logic        echo_m_q, echo_s_q, echo_d_q;
  logic        echo_rise, echo_fall;
  logic        pub_v, pub_to;
  logic [31:0] pub_w;
  logic [31:0] echo_width_q;
  logic        width_valid_q, timeout_q;

  // echo_s_q is the synchronized echo; echo_d_q is one cycle older for edge detection
  assign echo_rise = echo_s_q & ~echo_d_q;
  assign echo_fall = ~echo_s_q & echo_d_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pub_v     = 1'b0;
    pub_to    = 1'b0;
    pub_w     = cnt_q;
    no_echo_d = 1'b0;
    case (state_q)
      S_TRIG: begin
        // trig_q is still low in the first cycle out of reset, so counting waits for it
        if (trig_q) begin
          if (cnt_q >= TRIG_LAST) begin
            state_d = S_WAIT_RISE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
      S_WAIT_RISE: begin
        if (echo_rise) begin
          state_d = S_MEASURE;
          cnt_d   = 32'd1;
        end else if (cnt_q >= RISE_LAST) begin
          no_echo_d = 1'b1;
          state_d   = S_HOLDOFF;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_MEASURE: begin
        // a fall edge takes priority over the timeout in the same cycle
        if (echo_fall) begin
          pub_v   = 1'b1;
          pub_w   = cnt_q;
          state_d = S_HOLDOFF;
          cnt_d   = '0;
        end else if (cnt_q >= ECHO_MAX) begin
          pub_v   = 1'b1;
          pub_to  = 1'b1;
          pub_w   = ECHO_MAX;
          state_d = S_HOLDOFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_HOLDOFF: begin
        cnt_d = '0;
        if ((pcnt_q == PERIOD_LAST) && !echo_s_q) begin
          state_d = S_TRIG;
        end
      end
      default: begin
        state_d = S_TRIG;
        cnt_d   = '0;
      end
    endcase
  end

  assign trig_d = (state_d == S_TRIG);
  assign pcnt_d = (trig_d && !trig_q) ? '0 : sat_inc(pcnt_q, PERIOD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_TRIG;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      trig_q    <= 1'b0;
      no_echo_q <= 1'b0;
      echo_m_q  <= 1'b0;
      echo_s_q  <= 1'b0;
      echo_d_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      trig_q    <= trig_d;
      no_echo_q <= no_echo_d;
      echo_m_q  <= echo_in;
      echo_s_q  <= echo_m_q;
      echo_d_q  <= echo_s_q;
    end
  end

`ifdef ECHO_MEDIAN3_EN
  function automatic logic [31:0] median3(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    if (((a <= b) && (b <= c)) || ((c <= b) && (b <= a))) return b;
    if (((b <= a) && (a <= c)) || ((c <= a) && (a <= b))) return a;
    return c;
  endfunction

  logic [31:0] raw_w_q;
  logic        raw_v_q, raw_to_q;
  logic [31:0] win0_q, win1_q;
  logic        win_full_q;
  logic [31:0] med_w;

  // the first sample after reset stands for all three window entries
  assign med_w = win_full_q ? median3(raw_w_q, win0_q, win1_q) : raw_w_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_w_q       <= '0;
      raw_v_q       <= 1'b0;
      raw_to_q      <= 1'b0;
      win0_q        <= '0;
      win1_q        <= '0;
      win_full_q    <= 1'b0;
      echo_width_q  <= '0;
      width_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      raw_v_q       <= pub_v;
      raw_to_q      <= pub_to;
      width_valid_q <= raw_v_q;
      timeout_q     <= raw_to_q;
      if (pub_v) begin
        raw_w_q <= pub_w;
      end
      if (raw_v_q) begin
        echo_width_q <= med_w;
        win1_q       <= win_full_q ? win0_q : raw_w_q;
        win0_q       <= raw_w_q;
        win_full_q   <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_width_q  <= '0;
      width_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      width_valid_q <= pub_v;
      timeout_q     <= pub_to;
      if (pub_v) begin
        echo_width_q <= pub_w;
      end
    end
  end
`endif

  assign trig        = trig_q;
  assign echo_width  = echo_width_q;
  assign width_valid = width_valid_q;
  assign timeout     = timeout_q;
  assign no_echo     = no_echo_q;

endmodule

// File: tb/tb_echo_capture.sv
// Directed bench for echo_capture with short timing parameters.
module tb_echo_capture;
  localparam int TRIG_TICKS   = 4;
  localparam int PERIOD_TICKS = 200;
  localparam int RISE_TIMEOUT = 20;
  localparam int ECHO_TIMEOUT = 100;
`ifdef ECHO_MEDIAN3_EN
  localparam int PUB_LAT = 4;
`else
  localparam int PUB_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        echo_in = 1'b0;
  logic        trig, width_valid, timeout, no_echo;
  logic [31:0] echo_width;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;

  echo_capture #(
    .TRIG_TICKS  (TRIG_TICKS),
    .PERIOD_TICKS(PERIOD_TICKS),
    .RISE_TIMEOUT(RISE_TIMEOUT),
    .ECHO_TIMEOUT(ECHO_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .echo_in    (echo_in),
    .trig       (trig),
    .echo_width (echo_width),
    .width_valid(width_valid),
    .timeout    (timeout),
    .no_echo    (no_echo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    echo_in = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_trig_rise(output int c);
    logic prev;
    prev = trig;
    c = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (trig && !prev) begin
        c = cyc;
        break;
      end
      prev = trig;
    end
    if (c < 0) begin
      tests++; fails++;
      $display("FAIL trig_rise_wait: got no rise, required one within 1000 cycles");
    end
  endtask

  task automatic wait_trig_fall(output int c);
    logic prev;
    prev = trig;
    c = -1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!trig && prev) begin
        c = cyc;
        break;
      end
      prev = trig;
    end
    if (c < 0) begin
      tests++; fails++;
      $display("FAIL trig_fall_wait: got no fall, required one within 1000 cycles");
    end
  endtask

  // One ranging cycle with an echo pulse of w clock periods starting 5 cycles after trig fall.
  task automatic run_echo(input int w, output logic [31:0] got_w, output int nvalid,
                          output int nto, output int nco, output int lat);
    int c, cd, cv;
    wait_trig_rise(c);
    wait_trig_fall(c);
    repeat (5) @(negedge clk);
    echo_in = 1'b1;
    nvalid = 0; nto = 0; nco = 0; got_w = '0; cd = 0; cv = -1000;
    for (int i = 0; i < w + 20; i++) begin
      @(negedge clk);
      if (width_valid) begin
        nvalid++;
        got_w = echo_width;
        cv = cyc;
        if (timeout) nco++;
      end
      if (timeout) nto++;
      if (i == w - 1) begin
        echo_in = 1'b0;
        cd = cyc;
      end
    end
    lat = cv - cd;
  endtask

  task automatic test_reset();
    int rel, c0, c1, n;
    @(negedge clk);
    tests++; if (trig !== 1'b0) begin fails++; $display("FAIL rst_trig: got %b, required 0", trig); end
    tests++; if (echo_width !== 32'd0) begin fails++; $display("FAIL rst_width: got %0d, required 0", echo_width); end
    tests++; if (width_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b, required 0", width_valid); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b, required 0", timeout); end
    tests++; if (no_echo !== 1'b0) begin fails++; $display("FAIL rst_no_echo: got %b, required 0", no_echo); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    wait_trig_rise(c0);
    tests++; if (c0 - rel !== 1) begin fails++; $display("FAIL first_trig_delay: got %0d, required 1", c0 - rel); end
    n = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (trig) n++; else break;
    end
    tests++; if (n !== TRIG_TICKS) begin fails++; $display("FAIL trig_high_len: got %0d, required %0d", n, TRIG_TICKS); end
    wait_trig_rise(c1);
    tests++; if (c1 - c0 !== PERIOD_TICKS) begin fails++; $display("FAIL trig_period: got %0d, required %0d", c1 - c0, PERIOD_TICKS); end
  endtask

  task automatic test_width();
    logic [31:0] w;
    int nv, nto, nco, lat;
    do_reset();
    run_echo(50, w, nv, nto, nco, lat);
    tests++; if (nv !== 1) begin fails++; $display("FAIL width_valid_count: got %0d, required 1", nv); end
    tests++; if (w !== 32'd50) begin fails++; $display("FAIL width_value: got %0d, required 50", w); end
    tests++; if (nto !== 0) begin fails++; $display("FAIL width_no_timeout: got %0d, required 0", nto); end
    tests++; if (lat !== PUB_LAT) begin fails++; $display("FAIL width_latency: got %0d, required %0d", lat, PUB_LAT); end
    tests++; if (echo_width !== 32'd50) begin fails++; $display("FAIL width_held: got %0d, required 50", echo_width); end
  endtask

  task automatic test_timeout();
    logic [31:0] w;
    int nv, nto, nco, lat;
    do_reset();
    run_echo(150, w, nv, nto, nco, lat);
    tests++; if (nv !== 1) begin fails++; $display("FAIL to_valid_count: got %0d, required 1", nv); end
    tests++; if (w !== 32'd100) begin fails++; $display("FAIL to_width: got %0d, required 100", w); end
    tests++; if (nto !== 1) begin fails++; $display("FAIL to_pulse_count: got %0d, required 1", nto); end
    tests++; if (nco !== 1) begin fails++; $display("FAIL to_with_valid: got %0d, required 1", nco); end
  endtask

  task automatic test_holdoff();
    int c, cd, rc, rises;
    logic prev;
    do_reset();
    wait_trig_rise(c);
    wait_trig_fall(c);
    repeat (5) @(negedge clk);
    echo_in = 1'b1;
    rises = 0; rc = -1; cd = 0;
    prev = trig;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (trig && !prev) begin
        if (echo_in) rises++;
        else if (rc < 0) rc = cyc;
      end
      prev = trig;
      if (i == 259) begin
        echo_in = 1'b0;
        cd = cyc;
      end
    end
    tests++; if (rises !== 0) begin fails++; $display("FAIL holdoff_no_retrig: got %0d rises, required 0", rises); end
    tests++; if (rc - cd !== 3) begin fails++; $display("FAIL holdoff_retrig_delay: got %0d, required 3", rc - cd); end
  endtask

  task automatic test_no_echo();
    logic [31:0] w;
    int nv, nto, nco, lat, c, tf, n, nc, nvw;
    do_reset();
    run_echo(30, w, nv, nto, nco, lat);
    wait_trig_rise(c);
    wait_trig_fall(tf);
    n = 0; nc = -1; nvw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (no_echo) begin n++; nc = cyc; end
      if (width_valid) nvw++;
    end
    tests++; if (n !== 1) begin fails++; $display("FAIL no_echo_count: got %0d, required 1", n); end
    tests++; if (nc - tf !== RISE_TIMEOUT) begin fails++; $display("FAIL no_echo_delay: got %0d, required %0d", nc - tf, RISE_TIMEOUT); end
    tests++; if (echo_width !== 32'd30) begin fails++; $display("FAIL no_echo_width_kept: got %0d, required 30", echo_width); end
    tests++; if (nvw !== 0) begin fails++; $display("FAIL no_echo_valid: got %0d, required 0", nvw); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    int nv, nto, nco, lat, c, rel;
    do_reset();
    run_echo(30, w, nv, nto, nco, lat);
    wait_trig_rise(c);
    wait_trig_fall(c);
    repeat (5) @(negedge clk);
    echo_in = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if (echo_width !== 32'd30) begin fails++; $display("FAIL mid_width_before: got %0d, required 30", echo_width); end
    #2;
    reset   = 1'b1;
    echo_in = 1'b0;
    #1;
    tests++; if (trig !== 1'b0) begin fails++; $display("FAIL mid_trig: got %b, required 0", trig); end
    tests++; if (echo_width !== 32'd0) begin fails++; $display("FAIL mid_width_zero: got %0d, required 0", echo_width); end
    @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    wait_trig_rise(c);
    tests++; if (c - rel !== 1) begin fails++; $display("FAIL mid_retrig: got %0d, required 1", c - rel); end
    #2;
    reset = 1'b1;
    #1;
    tests++; if (trig !== 1'b0) begin fails++; $display("FAIL trig_abort: got %b, required 0", trig); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int          ws [4] = '{30, 90, 40, 150};
`ifdef ECHO_MEDIAN3_EN
    logic [31:0] ew [4] = '{32'd30, 32'd30, 32'd40, 32'd90};
`else
    logic [31:0] ew [4] = '{32'd30, 32'd90, 32'd40, 32'd100};
`endif
    int          et [4] = '{0, 0, 0, 1};
    logic [31:0] w;
    int nv, nto, nco, lat;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_echo(ws[k], w, nv, nto, nco, lat);
      tests++; if (w !== ew[k]) begin fails++; $display("FAIL seq_width[%0d]: got %0d, required %0d", k, w, ew[k]); end
      tests++; if (nco !== et[k]) begin fails++; $display("FAIL seq_timeout[%0d]: got %0d, required %0d", k, nco, et[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_width();
    test_timeout();
    test_holdoff();
    test_no_echo();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
